// File: rtl/time_adjust.sv
// time_adjust: debounces two raw adjust buttons into one-cycle Add/Subtract pulses for a mod-60 counter.
// Latency: first pulse is registered DEBOUNCE+3 edges after a clean press; repeats at +HOLD, then every REPEAT.
// Backpressure: none; pulses are one cycle wide, mutually exclusive, and never on consecutive cycles.
// Ports: Clk; Reset (synchronous, active-high); Key_Up/Key_Down (raw asynchronous buttons, active-high);
//        Add/Subtract (registered one-cycle pulses); Key_Held (high while auto-repeating).
// Build option: define TIME_ADJUST_REPEAT_EN to compile in the HOLD/REPEAT auto-repeat states.
module time_adjust #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned HOLD     = 16,
  parameter int unsigned REPEAT   = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Key_Up,
  input  logic Key_Down,
  output logic Add,
  output logic Subtract,
  output logic Key_Held
);

  // Elaboration-time parameter range checks.
  if (DEBOUNCE < 2 || DEBOUNCE > 255) begin : g_bad_debounce
    $error("time_adjust: DEBOUNCE must be in 2..255");
  end
  if (HOLD < 2 || HOLD > 255) begin : g_bad_hold
    $error("time_adjust: HOLD must be in 2..255");
  end
  if (REPEAT < 2 || REPEAT > 255) begin : g_bad_repeat
    $error("time_adjust: REPEAT must be in 2..255");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_HOLD     = 3'd2,
    S_REPEAT   = 3'd3,
    S_WAIT_REL = 3'd4
  } state_t;

  localparam logic [7:0] DEB_CNT = 8'(DEBOUNCE);
`ifdef TIME_ADJUST_REPEAT_EN
  localparam logic [7:0] HOLD_CNT = 8'(HOLD);
  localparam logic [7:0] REP_CNT  = 8'(REPEAT);
`endif

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n, cnt_inc;
  logic       dir_up, dir_up_n;
  logic       pulse;
  logic [1:0] up_sync, down_sync;
  logic [1:0] keys, cmd;
  logic       key_match, key_valid, pipe_clear;
  logic       released_q;

  // keys = {up_s, down_s}, the second synchronizer stages.
  assign keys      = {up_sync[1], down_sync[1]};
  assign cmd       = dir_up ? 2'b10 : 2'b01;
  assign key_match = (keys == cmd);
  assign key_valid = ^keys;
  assign cnt_inc   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  // Release is trusted only when both synchronizer stages are low and the
  // previous edge was also released. The synchronizers reset to zero, so
  // right after reset they hold no real sample yet; this keeps a key held
  // through reset from looking like a release followed by a fresh press.
  assign pipe_clear = (keys == 2'b00) && !up_sync[0] && !down_sync[0] && released_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      up_sync    <= 2'b00;
      down_sync  <= 2'b00;
      state      <= S_WAIT_REL;
      cnt        <= 8'd0;
      dir_up     <= 1'b0;
      released_q <= 1'b0;
      Add        <= 1'b0;
      Subtract   <= 1'b0;
    end else begin
      up_sync    <= {up_sync[0], Key_Up};
      down_sync  <= {down_sync[0], Key_Down};
      state      <= state_n;
      cnt        <= cnt_n;
      dir_up     <= dir_up_n;
      released_q <= (keys == 2'b00);
      Add        <= pulse & dir_up;
      Subtract   <= pulse & ~dir_up;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dir_up_n = dir_up;
    pulse    = 1'b0;
    case (state)
      S_IDLE: begin
        // Only a press rising out of an all-released pattern is fresh; a key
        // left over after a two-key chord is ignored until released.
        if (key_valid && released_q) begin
          dir_up_n = keys[1];
          cnt_n    = 8'd0;
          state_n  = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (!key_match) begin
          state_n = S_IDLE;
        end else if (cnt == DEB_CNT) begin
          pulse = 1'b1;
          cnt_n = 8'd1;
`ifdef TIME_ADJUST_REPEAT_EN
          state_n = S_HOLD;
`else
          state_n = S_WAIT_REL;
`endif
        end else begin
          cnt_n = cnt_inc;
        end
      end
`ifdef TIME_ADJUST_REPEAT_EN
      S_HOLD: begin
        // cnt counts cycles since the last pulse; release beats expiry.
        if (!key_match) begin
          state_n = S_WAIT_REL;
        end else if (cnt == HOLD_CNT) begin
          pulse   = 1'b1;
          cnt_n   = 8'd1;
          state_n = S_REPEAT;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_REPEAT: begin
        if (!key_match) begin
          state_n = S_WAIT_REL;
        end else if (cnt == REP_CNT) begin
          pulse = 1'b1;
          cnt_n = 8'd1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
`endif
      S_WAIT_REL: begin
        if (pipe_clear) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_WAIT_REL;
      end
    endcase
  end

`ifdef TIME_ADJUST_REPEAT_EN
  assign Key_Held = (state == S_HOLD) || (state == S_REPEAT);
`else
  assign Key_Held = 1'b0;
`endif

endmodule

// File: tb/tb_time_adjust.sv
// Bench for time_adjust: directed vector table, hand-written corner sequences,
// then random key traffic against a behavioural model of the press schedule.
module tb_time_adjust;
  localparam int DEB = 4;
  localparam int HLD = 16;
  localparam int RPT = 4;
`ifdef TIME_ADJUST_REPEAT_EN
  localparam bit HE = 1'b1;
`else
  localparam bit HE = 1'b0;
`endif

  logic Clk      = 1'b0;
  logic Reset    = 1'b1;
  logic Key_Up   = 1'b0;
  logic Key_Down = 1'b0;
  logic Add, Subtract, Key_Held;

  int checks = 0;
  int errors = 0;

  time_adjust #(.DEBOUNCE(DEB), .HOLD(HLD), .REPEAT(RPT)) dut (
    .Clk(Clk), .Reset(Reset), .Key_Up(Key_Up), .Key_Down(Key_Down),
    .Add(Add), .Subtract(Subtract), .Key_Held(Key_Held)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: raw keys are seen two edges late; a press counts only
  // if it rises from all-released; pulses fall at fixed ages after the press
  // starts; release is accepted once the raw keys were low on three edges.
  logic [1:0] m_d1, m_d2, m_prev, m_cmd;
  int m_quiet, m_age;
  bit m_locked, m_pressing, m_add, m_sub, m_held;

  task automatic model_step(input logic u, input logic d, input logic r);
    logic [1:0] p;
    bit pulse;
    p = m_d2;
    pulse = 1'b0;
    if (r) begin
      m_d1 = 2'b00; m_d2 = 2'b00; m_prev = 2'b11; m_quiet = 2;
      m_locked = 1'b1; m_pressing = 1'b0;
      m_add = 1'b0; m_sub = 1'b0; m_held = 1'b0;
    end else begin
      if (m_locked) begin
        if (m_quiet >= 3) m_locked = 1'b0;
      end else if (!m_pressing) begin
        if ((p == 2'b10 || p == 2'b01) && m_prev == 2'b00) begin
          m_pressing = 1'b1; m_cmd = p; m_age = 0;
        end
      end else begin
        m_age++;
        if (p != m_cmd) begin
          m_pressing = 1'b0;
          m_locked = (m_age > DEB + 1);
        end else if (m_age == DEB + 1) begin
          pulse = 1'b1;
          if (!HE) begin m_pressing = 1'b0; m_locked = 1'b1; end
        end else if (HE && m_age >= DEB + 1 + HLD && ((m_age - (DEB + 1 + HLD)) % RPT) == 0) begin
          pulse = 1'b1;
        end
      end
      m_add  = pulse && (m_cmd == 2'b10);
      m_sub  = pulse && (m_cmd == 2'b01);
      m_held = HE && m_pressing && (m_age >= DEB + 1);
      m_prev = p;
      m_d2 = m_d1;
      m_d1 = {u, d};
      if (u || d) m_quiet = 0;
      else if (m_quiet < 1000) m_quiet++;
    end
  endtask

  task automatic cyc(input logic u, input logic d, input logic r);
    Key_Up = u; Key_Down = d; Reset = r;
    @(posedge Clk);
    model_step(u, d, r);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic expect3(input string tag, input int e, input logic a, input logic s, input logic h);
    chk($sformatf("%s Add e%0d", tag, e), Add, a);
    chk($sformatf("%s Subtract e%0d", tag, e), Subtract, s);
    chk($sformatf("%s Key_Held e%0d", tag, e), Key_Held, h);
  endtask

  typedef struct packed {
    logic up, down, rst;
    logic add, sub, held;
  } vec_t;
  vec_t tbl[$];

  task automatic row(input logic u, input logic d, input logic r,
                     input logic a, input logic s, input logic h);
    vec_t v;
    v.up = u; v.down = d; v.rst = r; v.add = a; v.sub = s; v.held = h;
    tbl.push_back(v);
  endtask

  initial begin
    logic [6:0] bp;
    bp = 7'b1001011;  // Key_Down bounce 1,1,0,1,0,0,1 (bit e is edge e)

    // Reset state, then settle with keys released.
    row(0, 0, 1, 0, 0, 0);
    row(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) row(0, 0, 0, 0, 0, 0);
    // Basic press: Key_Up high for edges 0..9, one Add after edge 7.
    for (int e = 0; e < 18; e++) row(e < 10, 0, 0, e == 7, 0, HE && e >= 7 && e <= 11);
    // Bounce then hold: one Subtract 7 edges after the last rising edge (edge 6).
    for (int e = 0; e < 24; e++)
      row(0, (e < 7) ? bp[e] : (e < 16), 0, 0, e == 13, HE && e >= 13 && e <= 17);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].up, tbl[i].down, tbl[i].rst);
      expect3("table", i, tbl[i].add, tbl[i].sub, tbl[i].held);
    end

    // Auto-repeat: Key_Up held for edges 0..39; release seen at edge 42.
    for (int e = 0; e < 48; e++) begin
      cyc(e < 40, 0, 0);
      expect3("repeat", e,
              e == 7 || (HE && (e == 23 || e == 27 || e == 31 || e == 35 || e == 39)),
              0, HE && e >= 7 && e <= 41);
    end

    // Both keys, then Key_Up dropped: nothing until released and re-pressed.
    for (int e = 0; e < 56; e++) begin
      cyc(e < 10, (e < 30) || (e >= 38 && e < 48), 0);
      expect3("both", e, 0, e == 45, HE && e >= 45 && e <= 49);
    end

    // Key_Up held through reset: silent until released and pressed again.
    for (int e = 0; e < 49; e++) begin
      cyc((e < 23) || (e >= 31 && e < 41), 0, e < 3);
      expect3("rst_held", e, e == 38, 0, HE && e >= 38 && e <= 42);
    end

    // Reset mid-operation at edge 27: everything clears, no further pulses.
    for (int e = 0; e < 36; e++) begin
      cyc(e < 28, 0, e == 27);
      expect3("rst_mid", e, e == 7 || (HE && e == 23), 0, HE && e >= 7 && e <= 26);
    end

    // Random key traffic with occasional reset, compared against the model.
    begin
      int n;
      n = 0;
      while (n < 3000) begin
        int sel, len;
        logic u, d;
        sel = $urandom_range(0, 9);
        u = (sel >= 4 && sel <= 6) || (sel == 9);
        d = (sel >= 7);
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 45);
        for (int k = 0; k < len; k++) begin
          logic r;
          r = ($urandom_range(0, 299) == 0);
          cyc(u, d, r);
          expect3("random", n, m_add, m_sub, m_held);
          n++;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
